// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
// Multicycle control sequencer for the RV32I datapath. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, drives the datapath
// enables/selects and counts retired instructions.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   async active-low reset
//   mem_rdata     in   memory read data (instruction in FETCH)
//   mem_ready     in   memory completes the access this cycle
//   branch_taken  in   branch comparator result, valid in EXEC
//   mem_req       out  memory access request, held until mem_ready
//   mem_we        out  store strobe, qualified by mem_req
//   ir_we         out  instruction register load pulse
//   pc_we         out  PC update pulse
//   pc_src        out  next PC: 0=pc+4, 1=pc+imm, 2=alu_result
//   imm_src       out  immediate format for the sign-extend unit
//   alu_src_b     out  ALU B input: 0=rs2, 1=immediate
//   result_src    out  writeback: 0=alu, 1=mem, 2=pc+4, 3=imm
//   reg_we        out  register-file write pulse
//   illegal       out  sticky: an unknown opcode was decoded
//   instret       out  retired-instruction count, wraps
//
// state  | meaning
// FETCH  | request instruction, load IR on mem_ready
// DECODE | classify opcode, trap on unknown
// EXEC   | ALU op and PC update
// MEM    | data access for load/store
// WB     | register-file write
// TRAP   | unknown opcode, wait for reset
module multicycle_ctrl_fsm #(
    parameter int IMM_W = 3,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [IMM_W-1:0] imm_src,
    output logic             alu_src_b,
    output logic [1:0]       result_src,
    output logic             reg_we,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [IMM_W-1:0] I_TYPE  = IMM_W'(0);
    localparam logic [IMM_W-1:0] S_TYPE  = IMM_W'(1);
    localparam logic [IMM_W-1:0] B_TYPE  = IMM_W'(2);
    localparam logic [IMM_W-1:0] U_TYPE  = IMM_W'(3);
    localparam logic [IMM_W-1:0] J_TYPE  = IMM_W'(4);
    localparam logic [IMM_W-1:0] NE_TYPE = IMM_W'(5);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      ir_q;
    logic [CNT_W-1:0] instret_q;
    logic             illegal_q;
    logic [6:0]       opcode;
    logic             known, retire, set_illegal;
    logic             mem_req_c, mem_we_c, ir_we_c, pc_we_c, alu_src_b_c, reg_we_c;
    logic [1:0]       pc_src_c, result_src_c;
    logic             ir_unused;

    assign opcode    = ir_q[6:0];
    // Only the opcode steers sequencing; the rest of IR feeds the datapath.
    assign ir_unused = ^ir_q[31:7];

    // IR only changes at the end of FETCH, so the decoded format stays
    // stable from DECODE until the next instruction is loaded.
    always_comb begin
        imm_src = I_TYPE;
        known   = 1'b1;
        case (opcode)
            OP_R:                      imm_src = NE_TYPE;
            OP_IMM, OP_LOAD, OP_JALR:  imm_src = I_TYPE;
            OP_STORE:                  imm_src = S_TYPE;
            OP_BRANCH:                 imm_src = B_TYPE;
            OP_LUI, OP_AUIPC:          imm_src = U_TYPE;
            OP_JAL:                    imm_src = J_TYPE;
            default:                   known   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ir_we_c)     ir_q      <= mem_rdata;
            if (retire)      instret_q <= instret_q + CNT_W'(1);
            if (set_illegal) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        set_illegal  = 1'b0;
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        ir_we_c      = 1'b0;
        pc_we_c      = 1'b0;
        pc_src_c     = 2'd0;
        alu_src_b_c  = 1'b0;
        result_src_c = 2'd0;
        reg_we_c     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (known) begin
                    state_d = S_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_EXEC: begin
                pc_we_c     = 1'b1;
                alu_src_b_c = !(opcode == OP_R || opcode == OP_BRANCH);
                if (opcode == OP_BRANCH)    pc_src_c = branch_taken ? 2'd1 : 2'd0;
                else if (opcode == OP_JAL)  pc_src_c = 2'd1;
                else if (opcode == OP_JALR) pc_src_c = 2'd2;
                if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = S_MEM;
                end else if (opcode == OP_BRANCH) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            S_WB: begin
                reg_we_c = 1'b1;
                if (opcode == OP_LOAD)                         result_src_c = 2'd1;
                else if (opcode == OP_JAL || opcode == OP_JALR) result_src_c = 2'd2;
                else if (opcode == OP_LUI)                     result_src_c = 2'd3;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase
    end

    // The state register resets into FETCH, whose request would otherwise
    // be visible while reset is still held; gate every strobe with rst_n.
    assign mem_req    = mem_req_c   & rst_n;
    assign mem_we     = mem_we_c    & rst_n;
    assign ir_we      = ir_we_c     & rst_n;
    assign pc_we      = pc_we_c     & rst_n;
    assign alu_src_b  = alu_src_b_c & rst_n;
    assign reg_we     = reg_we_c    & rst_n;
    assign pc_src     = rst_n ? pc_src_c     : 2'd0;
    assign result_src = rst_n ? result_src_c : 2'd0;
    assign illegal    = illegal_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    logic        clk, rst_n;
    logic [31:0] mem_rdata;
    logic        mem_ready, branch_taken;
    logic        mem_req, mem_we, ir_we, pc_we, alu_src_b, reg_we, illegal;
    logic [1:0]  pc_src, result_src;
    logic [2:0]  imm_src;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_instret = 0;

    localparam logic [2:0] I_T = 3'd0, S_T = 3'd1, B_T = 3'd2, U_T = 3'd3, J_T = 3'd4, NE_T = 3'd5;

    // per-cycle record of one instruction run (index 1 = FETCH cycle)
    logic        r_ir [0:15], r_pc [0:15], r_reg [0:15], r_req [0:15], r_we [0:15], r_altb [0:15], r_ill [0:15];
    logic [1:0]  r_pcs [0:15], r_res [0:15];
    logic [2:0]  r_imm [0:15];
    logic [31:0] r_inst [0:15];

    multicycle_ctrl_fsm #(.IMM_W(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .imm_src(imm_src), .alu_src_b(alu_src_b),
        .result_src(result_src), .reg_we(reg_we), .illegal(illegal), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic record(input int c);
        r_ir[c] = ir_we; r_pc[c] = pc_we; r_reg[c] = reg_we; r_req[c] = mem_req; r_we[c] = mem_we;
        r_altb[c] = alu_src_b; r_pcs[c] = pc_src; r_res[c] = result_src; r_imm[c] = imm_src;
        r_inst[c] = instret; r_ill[c] = illegal;
    endtask

    // Runs n cycles starting at a negedge in FETCH; mem_ready is low for
    // `waits` cycles starting at cycle mem_start. Cycle n+1 is recorded with
    // mem_ready low so the FSM stalls in FETCH afterwards.
    task automatic run_cycles(input logic [31:0] instr, input int n, input int mem_start,
                              input int waits, input logic br);
        for (int c = 1; c <= n; c++) begin
            mem_ready    = (c >= mem_start && c < mem_start + waits) ? 1'b0 : 1'b1;
            mem_rdata    = (c == 1) ? instr : 32'hDEAD_BEEF;
            branch_taken = br;
            #1 record(c);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        #1 record(n + 1);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0050_0093; branch_taken = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0b want=0", mem_req); end
        checks++; if ({ir_we, pc_we, reg_we, mem_we, alu_src_b} !== 5'b0) begin errors++; $display("FAIL reset_strobes got=%b want=00000", {ir_we, pc_we, reg_we, mem_we, alu_src_b}); end
        checks++; if ({pc_src, result_src} !== 4'b0) begin errors++; $display("FAIL reset_selects got=%b want=0000", {pc_src, result_src}); end
        checks++; if (imm_src !== I_T) begin errors++; $display("FAIL reset_imm_src got=%0d want=%0d", imm_src, I_T); end
        checks++; if (instret !== 32'd0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_instret_illegal got=%0d/%0b want=0/0", instret, illegal); end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || ir_we !== 1'b0) begin errors++; $display("FAIL reset_release_fetch got req=%0b ir=%0b want req=1 ir=0", mem_req, ir_we); end
        @(negedge clk);
        exp_instret = 0;
    endtask

    task automatic test_addi;
        int npc, nreg, nir, overlap;
        run_cycles(32'h0050_0093, 4, 99, 0, 1'b0);
        exp_instret++;
        checks++; if (r_ir[1] !== 1'b1 || r_req[1] !== 1'b1) begin errors++; $display("FAIL addi_fetch got ir=%0b req=%0b want 1/1", r_ir[1], r_req[1]); end
        checks++; if (r_imm[2] !== I_T) begin errors++; $display("FAIL addi_imm_src got=%0d want=%0d", r_imm[2], I_T); end
        checks++; if (r_pc[3] !== 1'b1 || r_pcs[3] !== 2'd0 || r_altb[3] !== 1'b1) begin errors++; $display("FAIL addi_exec got pc_we=%0b pc_src=%0d alu_b=%0b want 1/0/1", r_pc[3], r_pcs[3], r_altb[3]); end
        checks++; if (r_reg[4] !== 1'b1 || r_res[4] !== 2'd0) begin errors++; $display("FAIL addi_wb got reg_we=%0b res=%0d want 1/0", r_reg[4], r_res[4]); end
        checks++; if (r_req[5] !== 1'b1 || r_reg[5] !== 1'b0) begin errors++; $display("FAIL addi_latency got req=%0b reg=%0b at cycle 5 want 1/0", r_req[5], r_reg[5]); end
        checks++; if (r_inst[5] !== exp_instret) begin errors++; $display("FAIL addi_instret got=%0d want=%0d", r_inst[5], exp_instret); end
        npc = 0; nreg = 0; nir = 0; overlap = 0;
        for (int c = 1; c <= 4; c++) begin
            npc += int'(r_pc[c]); nreg += int'(r_reg[c]); nir += int'(r_ir[c]);
            if (int'(r_pc[c]) + int'(r_reg[c]) + int'(r_ir[c]) > 1) overlap++;
        end
        checks++; if (npc != 1 || nreg != 1 || nir != 1 || overlap != 0) begin errors++; $display("FAIL addi_pulses got pc=%0d reg=%0d ir=%0d overlap=%0d want 1/1/1/0", npc, nreg, nir, overlap); end
    endtask

    task automatic test_load_wait;
        int nreq;
        run_cycles(32'h0000_A083, 7, 4, 2, 1'b0);
        exp_instret++;
        nreq = 0;
        for (int c = 4; c <= 6; c++) nreq += int'(r_req[c]);
        checks++; if (nreq != 3 || r_we[4] !== 1'b0 || r_we[5] !== 1'b0 || r_we[6] !== 1'b0) begin errors++; $display("FAIL load_mem_req got req_cycles=%0d we=%0b%0b%0b want 3/000", nreq, r_we[4], r_we[5], r_we[6]); end
        checks++; if (r_reg[6] !== 1'b0 || r_reg[7] !== 1'b1 || r_res[7] !== 2'd1) begin errors++; $display("FAIL load_wb got reg6=%0b reg7=%0b res=%0d want 0/1/1", r_reg[6], r_reg[7], r_res[7]); end
        checks++; if (r_req[8] !== 1'b1 || r_inst[8] !== exp_instret) begin errors++; $display("FAIL load_latency got req8=%0b instret=%0d want 1/%0d", r_req[8], r_inst[8], exp_instret); end
    endtask

    task automatic test_branch;
        for (int t = 0; t < 2; t++) begin
            logic br;
            br = (t == 0);
            run_cycles(32'h0000_0463, 3, 99, 0, br);
            exp_instret++;
            checks++; if (r_imm[2] !== B_T || r_altb[3] !== 1'b0) begin errors++; $display("FAIL branch_imm got imm=%0d alu_b=%0b want %0d/0", r_imm[2], r_altb[3], B_T); end
            checks++; if (r_pc[3] !== 1'b1 || r_pcs[3] !== (br ? 2'd1 : 2'd0)) begin errors++; $display("FAIL branch_pc_src taken=%0b got pc_we=%0b src=%0d want 1/%0d", br, r_pc[3], r_pcs[3], br ? 1 : 0); end
            checks++; if ((r_reg[1] | r_reg[2] | r_reg[3] | r_reg[4]) !== 1'b0 || r_req[4] !== 1'b1 || r_inst[4] !== exp_instret) begin errors++; $display("FAIL branch_retire got any_reg=%0b req4=%0b instret=%0d want 0/1/%0d", r_reg[1] | r_reg[2] | r_reg[3] | r_reg[4], r_req[4], r_inst[4], exp_instret); end
        end
    endtask

    task automatic test_store;
        run_cycles(32'h0010_A023, 4, 4, 0, 1'b0);
        exp_instret++;
        checks++; if (r_imm[2] !== S_T) begin errors++; $display("FAIL store_imm got=%0d want=%0d", r_imm[2], S_T); end
        checks++; if (r_req[4] !== 1'b1 || r_we[4] !== 1'b1 || r_altb[3] !== 1'b1) begin errors++; $display("FAIL store_mem got req=%0b we=%0b alu_b=%0b want 1/1/1", r_req[4], r_we[4], r_altb[3]); end
        checks++; if ((r_reg[1] | r_reg[2] | r_reg[3] | r_reg[4] | r_reg[5]) !== 1'b0) begin errors++; $display("FAIL store_no_reg_we got reg_we seen"); end
        checks++; if (r_req[5] !== 1'b1 || r_we[5] !== 1'b0 || r_inst[5] !== exp_instret) begin errors++; $display("FAIL store_retire got req=%0b we=%0b instret=%0d want 1/0/%0d", r_req[5], r_we[5], r_inst[5], exp_instret); end
    endtask

    task automatic test_opcodes;
        logic [31:0] ins [5];
        logic [2:0]  eimm [5];
        logic [1:0]  epcs [5];
        logic        ealtb [5];
        logic [1:0]  eres [5];
        ins   = '{32'h0020_81B3, 32'h0000_12B7, 32'h0000_1317, 32'h0080_00EF, 32'h0000_80E7};
        eimm  = '{NE_T, U_T, U_T, J_T, I_T};
        epcs  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
        ealtb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        eres  = '{2'd0, 2'd3, 2'd0, 2'd2, 2'd2};
        for (int k = 0; k < 5; k++) begin
            run_cycles(ins[k], 4, 99, 0, 1'b1);
            exp_instret++;
            checks++; if (r_imm[2] !== eimm[k] || r_imm[4] !== eimm[k]) begin errors++; $display("FAIL op_imm instr=%h got=%0d/%0d want=%0d", ins[k], r_imm[2], r_imm[4], eimm[k]); end
            checks++; if (r_pc[3] !== 1'b1 || r_pcs[3] !== epcs[k] || r_altb[3] !== ealtb[k]) begin errors++; $display("FAIL op_exec instr=%h got pc_we=%0b src=%0d alu_b=%0b want 1/%0d/%0b", ins[k], r_pc[3], r_pcs[3], r_altb[3], epcs[k], ealtb[k]); end
            checks++; if (r_reg[4] !== 1'b1 || r_res[4] !== eres[k] || r_inst[5] !== exp_instret) begin errors++; $display("FAIL op_wb instr=%h got reg=%0b res=%0d instret=%0d want 1/%0d/%0d", ins[k], r_reg[4], r_res[4], r_inst[5], eres[k], exp_instret); end
        end
    endtask

    task automatic test_illegal;
        int strobes;
        run_cycles(32'h0000_007F, 2, 99, 0, 1'b0);
        checks++; if (r_ill[2] !== 1'b0 || r_ill[3] !== 1'b1) begin errors++; $display("FAIL illegal_set got decode=%0b after=%0b want 0/1", r_ill[2], r_ill[3]); end
        strobes = 0;
        mem_ready = 1'b1; branch_taken = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1 strobes += int'(mem_req) + int'(mem_we) + int'(ir_we) + int'(pc_we) + int'(reg_we);
            @(negedge clk);
        end
        checks++; if (strobes != 0 || illegal !== 1'b1 || instret !== exp_instret) begin errors++; $display("FAIL illegal_trap got strobes=%0d illegal=%0b instret=%0d want 0/1/%0d", strobes, illegal, instret, exp_instret); end
        rst_n = 1'b0; mem_ready = 1'b0;
        #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear got=%0b want=0", illegal); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_instret = 0;
        #1;
        checks++; if (mem_req !== 1'b1 || instret !== 32'd0) begin errors++; $display("FAIL illegal_restart got req=%0b instret=%0d want 1/0", mem_req, instret); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load;
        int nreg;
        run_cycles(32'h0000_A083, 3, 4, 0, 1'b0);
        checks++; if (r_req[4] !== 1'b1) begin errors++; $display("FAIL midrst_in_mem got req=%0b want 1", r_req[4]); end
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_req, mem_we, ir_we, pc_we, reg_we} !== 5'b0) begin errors++; $display("FAIL midrst_outputs got=%b want=00000", {mem_req, mem_we, ir_we, pc_we, reg_we}); end
        nreg = 0;
        mem_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1 nreg += int'(reg_we) + int'(pc_we);
        end
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1 nreg += int'(reg_we) + int'(pc_we);
        checks++; if (nreg != 0 || mem_req !== 1'b1 || instret !== 32'd0) begin errors++; $display("FAIL midrst_restart got partial=%0d req=%0b instret=%0d want 0/1/0", nreg, mem_req, instret); end
        @(negedge clk);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        @(negedge clk);
        run_cycles(32'h0050_0093, 4, 99, 0, 1'b0);
        checks++; if (r_inst[4] !== 32'hFFFF_FFFF || r_inst[5] !== 32'd0) begin errors++; $display("FAIL instret_wrap got before=%h after=%h want ffffffff/0", r_inst[4], r_inst[5]); end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_load_wait;
        test_branch;
        test_store;
        test_opcodes;
        test_illegal;
        test_reset_mid_load;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish within 200000 time units");
        $fatal(1);
    end

endmodule
